// File: rtl/reg_scoreboard_if.sv
// Slot, writeback and status bundle between the decode stage and reg_scoreboard.
// Slot k matches register-file port set k; writeback signals mirror RegWr_k/Rw_k.
interface reg_scoreboard_if;
  logic       iv1, iv2, iv3;
  logic [4:0] rs1, rs2, rs3, rt1, rt2, rt3;
  logic       rsv1, rsv2, rsv3, rtv1, rtv2, rtv3;
  logic [4:0] rd1, rd2, rd3;
  logic       rdv1, rdv2, rdv3;
  logic       wb_en1, wb_en2, wb_en3;
  logic [4:0] wb_rd1, wb_rd2, wb_rd3;
  logic        grant1, grant2, grant3;
  logic [31:0] busy_vec;
  logic [5:0]  busy_cnt;
  logic        wb_err;

  modport master (
    output iv1, iv2, iv3, rs1, rs2, rs3, rt1, rt2, rt3,
           rsv1, rsv2, rsv3, rtv1, rtv2, rtv3, rd1, rd2, rd3, rdv1, rdv2, rdv3,
           wb_en1, wb_en2, wb_en3, wb_rd1, wb_rd2, wb_rd3,
    input  grant1, grant2, grant3, busy_vec, busy_cnt, wb_err
  );

  modport slave (
    input  iv1, iv2, iv3, rs1, rs2, rs3, rt1, rt2, rt3,
           rsv1, rsv2, rsv3, rtv1, rtv2, rtv3, rd1, rd2, rd3, rdv1, rdv2, rdv3,
           wb_en1, wb_en2, wb_en3, wb_rd1, wb_rd2, wb_rd3,
    output grant1, grant2, grant3, busy_vec, busy_cnt, wb_err
  );
endinterface

// File: rtl/reg_scoreboard.sv
// Register-busy scoreboard for the 3-wide issue group: grants an in-order hazard-free prefix.
// Define SB_WB_BYPASS_EN to treat same-cycle writeback targets as free (downstream forwards busW).
module reg_scoreboard #(
  parameter int NREG = 32
) (
  input  logic            clk,
  input  logic            rst_n,
  input  logic            flush,
  reg_scoreboard_if.slave sb
);
  localparam int IDXW = $clog2(NREG);

  logic [2:0]            iv, rsv, rtv, rdv, wbEn, grant;
  logic [2:0][IDXW-1:0]  rs, rt, rd, wbRd;
  logic [NREG-1:0]       wbVec, freeVec, setVec, busyNext;
  logic                  chain, ok, wbErrNow;
  logic [NREG-1:0]       busyVec_p1;
  logic [5:0]            busyCnt_p1;
  logic                  wbErr_p1;

  function automatic logic [5:0] popCount(input logic [NREG-1:0] v);
    logic [5:0] c;
    c = '0;
    for (int i = 0; i < NREG; i++) c = c + 6'(v[i]);
    return c;
  endfunction

  assign iv   = {sb.iv3, sb.iv2, sb.iv1};
  assign rsv  = {sb.rsv3, sb.rsv2, sb.rsv1};
  assign rtv  = {sb.rtv3, sb.rtv2, sb.rtv1};
  assign rdv  = {sb.rdv3, sb.rdv2, sb.rdv1};
  assign wbEn = {sb.wb_en3, sb.wb_en2, sb.wb_en1};
  assign rs   = {sb.rs3, sb.rs2, sb.rs1};
  assign rt   = {sb.rt3, sb.rt2, sb.rt1};
  assign rd   = {sb.rd3, sb.rd2, sb.rd1};
  assign wbRd = {sb.wb_rd3, sb.wb_rd2, sb.wb_rd1};

  always_comb begin
    wbVec = '0;
    for (int k = 0; k < 3; k++)
      if (wbEn[k]) wbVec[wbRd[k]] = 1'b1;
    wbVec[0] = 1'b0;
  end

`ifdef SB_WB_BYPASS_EN
  assign freeVec = ~busyVec_p1 | wbVec;
`else
  assign freeVec = ~busyVec_p1;
`endif

  // setVec doubles as the set of destinations claimed by earlier slots in the group.
  always_comb begin
    grant  = '0;
    setVec = '0;
    ok     = 1'b0;
    chain  = !flush;
    for (int k = 0; k < 3; k++) begin
      ok = chain & iv[k];
      if (rsv[k] && rs[k] != '0) ok = ok & freeVec[rs[k]] & ~setVec[rs[k]];
      if (rtv[k] && rt[k] != '0) ok = ok & freeVec[rt[k]] & ~setVec[rt[k]];
      if (rdv[k] && rd[k] != '0) ok = ok & freeVec[rd[k]] & ~setVec[rd[k]];
      grant[k] = ok;
      chain    = ok;
      if (ok && rdv[k] && rd[k] != '0) setVec[rd[k]] = 1'b1;
    end
  end

  always_comb begin
    busyNext    = flush ? '0 : ((busyVec_p1 & ~wbVec) | setVec);
    busyNext[0] = 1'b0;
    wbErrNow    = 1'b0;
    if (!flush)
      for (int k = 0; k < 3; k++)
        if (wbEn[k] && (wbRd[k] == '0 || !busyVec_p1[wbRd[k]])) wbErrNow = 1'b1;
  end

  // ---- state register stage ----
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      busyVec_p1 <= '0;
      busyCnt_p1 <= '0;
      wbErr_p1   <= 1'b0;
    end else begin
      busyVec_p1 <= busyNext;
      busyCnt_p1 <= popCount(busyNext);
      wbErr_p1   <= wbErr_p1 | wbErrNow;
    end
  end

  assign sb.grant1   = grant[0];
  assign sb.grant2   = grant[1];
  assign sb.grant3   = grant[2];
  assign sb.busy_vec = busyVec_p1;
  assign sb.busy_cnt = busyCnt_p1;
  assign sb.wb_err   = wbErr_p1;
endmodule

// File: tb/tb_reg_scoreboard.sv
// Directed table-driven bench for reg_scoreboard plus hand sequences for async reset.
module tb_reg_scoreboard;
  logic clk = 1'b0;
  logic rst_n;
  logic flush;
  int   checks = 0;
  int   errors = 0;

  reg_scoreboard_if sbIf ();

  reg_scoreboard #(.NREG(32)) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .flush (flush),
    .sb    (sbIf)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic            flush;
    logic [2:0]      iv;
    logic [2:0][4:0] rs;
    logic [2:0]      rsv;
    logic [2:0][4:0] rt;
    logic [2:0]      rtv;
    logic [2:0][4:0] rd;
    logic [2:0]      rdv;
    logic [2:0]      wbEn;
    logic [2:0][4:0] wbRd;
    logic [2:0]      expGrant;
    logic [31:0]     expBusy;
    logic [5:0]      expCnt;
    logic            expErr;
  } vec_t;

  vec_t vecs[$];

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
    end
  endtask

  task automatic apply(input vec_t v);
    flush       = v.flush;
    sbIf.iv1    = v.iv[0];   sbIf.iv2    = v.iv[1];   sbIf.iv3    = v.iv[2];
    sbIf.rs1    = v.rs[0];   sbIf.rs2    = v.rs[1];   sbIf.rs3    = v.rs[2];
    sbIf.rsv1   = v.rsv[0];  sbIf.rsv2   = v.rsv[1];  sbIf.rsv3   = v.rsv[2];
    sbIf.rt1    = v.rt[0];   sbIf.rt2    = v.rt[1];   sbIf.rt3    = v.rt[2];
    sbIf.rtv1   = v.rtv[0];  sbIf.rtv2   = v.rtv[1];  sbIf.rtv3   = v.rtv[2];
    sbIf.rd1    = v.rd[0];   sbIf.rd2    = v.rd[1];   sbIf.rd3    = v.rd[2];
    sbIf.rdv1   = v.rdv[0];  sbIf.rdv2   = v.rdv[1];  sbIf.rdv3   = v.rdv[2];
    sbIf.wb_en1 = v.wbEn[0]; sbIf.wb_en2 = v.wbEn[1]; sbIf.wb_en3 = v.wbEn[2];
    sbIf.wb_rd1 = v.wbRd[0]; sbIf.wb_rd2 = v.wbRd[1]; sbIf.wb_rd3 = v.wbRd[2];
  endtask

  initial begin
    vec_t idle;
    vec_t v;
    idle = '{1'b0, 3'b000, 15'd0, 3'b000, 15'd0, 3'b000, 15'd0, 3'b000, 3'b000, 15'd0,
             3'b000, 32'h0, 6'd0, 1'b0};

    // fields: flush, iv, rs{s3,s2,s1}, rsv, rt, rtv, rd, rdv, wbEn, wbRd, expGrant, expBusy, expCnt, expErr
    // r3<-r1,r2 / r4<-r5 / r6<-r7: all independent
    vecs.push_back('{1'b0, 3'b111, {5'd7,5'd5,5'd1}, 3'b111, {5'd0,5'd0,5'd2}, 3'b001,
                     {5'd6,5'd4,5'd3}, 3'b111, 3'b000, 15'd0, 3'b111, 32'h58, 6'd3, 1'b0});
    vecs.push_back('{1'b0, 3'b000, 15'd0, 3'b000, 15'd0, 3'b000, 15'd0, 3'b000,
                     3'b111, {5'd6,5'd4,5'd3}, 3'b000, 32'h0, 6'd0, 1'b0});
    // flush with a stray writeback and a valid slot: no grant, no error
    vecs.push_back('{1'b1, 3'b001, {5'd0,5'd0,5'd1}, 3'b001, 15'd0, 3'b000,
                     {5'd0,5'd0,5'd2}, 3'b001, 3'b001, {5'd0,5'd0,5'd15}, 3'b000, 32'h0, 6'd0, 1'b0});
    // slot1 writes r8, slot2 reads r8, slot3 independent -> prefix of one
    vecs.push_back('{1'b0, 3'b111, {5'd2,5'd8,5'd1}, 3'b111, 15'd0, 3'b000,
                     {5'd13,5'd11,5'd8}, 3'b111, 3'b000, 15'd0, 3'b001, 32'h100, 6'd1, 1'b0});
    vecs.push_back('{1'b0, 3'b011, {5'd0,5'd1,5'd8}, 3'b011, 15'd0, 3'b000,
                     15'd0, 3'b000, 3'b000, 15'd0, 3'b000, 32'h100, 6'd1, 1'b0});
    // slot2 writes r0 with rdv set: granted, nothing marked
    vecs.push_back('{1'b0, 3'b011, 15'd0, 3'b000, 15'd0, 3'b000,
                     {5'd0,5'd0,5'd9}, 3'b011, 3'b000, 15'd0, 3'b011, 32'h300, 6'd2, 1'b0});
`ifdef SB_WB_BYPASS_EN
    vecs.push_back('{1'b0, 3'b001, {5'd0,5'd0,5'd9}, 3'b001, 15'd0, 3'b000,
                     15'd0, 3'b000, 3'b010, {5'd0,5'd9,5'd0}, 3'b001, 32'h100, 6'd1, 1'b0});
`else
    vecs.push_back('{1'b0, 3'b001, {5'd0,5'd0,5'd9}, 3'b001, 15'd0, 3'b000,
                     15'd0, 3'b000, 3'b010, {5'd0,5'd9,5'd0}, 3'b000, 32'h100, 6'd1, 1'b0});
`endif
    vecs.push_back('{1'b0, 3'b001, {5'd0,5'd0,5'd9}, 3'b001, 15'd0, 3'b000,
                     15'd0, 3'b000, 3'b000, 15'd0, 3'b001, 32'h100, 6'd1, 1'b0});
    // slot2 names busy r8 but does not read it
    vecs.push_back('{1'b0, 3'b011, {5'd0,5'd8,5'd0}, 3'b000, 15'd0, 3'b000,
                     {5'd0,5'd0,5'd10}, 3'b001, 3'b000, 15'd0, 3'b011, 32'h500, 6'd2, 1'b0});
`ifdef SB_WB_BYPASS_EN
    vecs.push_back('{1'b0, 3'b001, 15'd0, 3'b000, 15'd0, 3'b000,
                     {5'd0,5'd0,5'd10}, 3'b001, 3'b001, {5'd0,5'd0,5'd10}, 3'b001, 32'h500, 6'd2, 1'b0});
    vecs.push_back('{1'b0, 3'b001, 15'd0, 3'b000, 15'd0, 3'b000,
                     {5'd0,5'd0,5'd10}, 3'b001, 3'b000, 15'd0, 3'b000, 32'h500, 6'd2, 1'b0});
`else
    vecs.push_back('{1'b0, 3'b001, 15'd0, 3'b000, 15'd0, 3'b000,
                     {5'd0,5'd0,5'd10}, 3'b001, 3'b001, {5'd0,5'd0,5'd10}, 3'b000, 32'h100, 6'd1, 1'b0});
    vecs.push_back('{1'b0, 3'b001, 15'd0, 3'b000, 15'd0, 3'b000,
                     {5'd0,5'd0,5'd10}, 3'b001, 3'b000, 15'd0, 3'b001, 32'h500, 6'd2, 1'b0});
`endif
    // duplicate writebacks to r10 clear it once, no error
    vecs.push_back('{1'b0, 3'b000, 15'd0, 3'b000, 15'd0, 3'b000, 15'd0, 3'b000,
                     3'b111, {5'd10,5'd10,5'd8}, 3'b000, 32'h0, 6'd0, 1'b0});
    // grant writing r12 while r12 (not busy) is written back: set wins, error raised
    vecs.push_back('{1'b0, 3'b001, 15'd0, 3'b000, 15'd0, 3'b000,
                     {5'd0,5'd0,5'd12}, 3'b001, 3'b100, {5'd12,5'd0,5'd0}, 3'b001, 32'h1000, 6'd1, 1'b1});
    vecs.push_back('{1'b0, 3'b000, 15'd0, 3'b000, 15'd0, 3'b000, 15'd0, 3'b000,
                     3'b011, {5'd0,5'd12,5'd0}, 3'b000, 32'h0, 6'd0, 1'b1});
    vecs.push_back('{1'b0, 3'b111, 15'd0, 3'b000, 15'd0, 3'b000,
                     {5'd3,5'd2,5'd1}, 3'b111, 3'b000, 15'd0, 3'b111, 32'hE, 6'd3, 1'b1});
    // slot3 writes the same rd as slot1: intra-group WAW
    vecs.push_back('{1'b0, 3'b111, 15'd0, 3'b000, {5'd0,5'd0,5'd0}, 3'b000,
                     {5'd4,5'd5,5'd4}, 3'b111, 3'b000, 15'd0, 3'b011, 32'h3E, 6'd5, 1'b1});
    // slot2 reads slot1's rd through rt: intra-group RAW
    vecs.push_back('{1'b0, 3'b011, 15'd0, 3'b000, {5'd0,5'd7,5'd0}, 3'b010,
                     {5'd0,5'd0,5'd7}, 3'b001, 3'b000, 15'd0, 3'b001, 32'hBE, 6'd6, 1'b1});
    vecs.push_back('{1'b1, 3'b111, 15'd0, 3'b000, 15'd0, 3'b000,
                     {5'd22,5'd21,5'd20}, 3'b111, 3'b000, 15'd0, 3'b000, 32'h0, 6'd0, 1'b1});
    vecs.push_back('{1'b0, 3'b001, 15'd0, 3'b000, 15'd0, 3'b000,
                     {5'd0,5'd0,5'd1}, 3'b001, 3'b000, 15'd0, 3'b001, 32'h2, 6'd1, 1'b1});

    rst_n = 1'b0;
    apply(idle);
    repeat (2) @(posedge clk);
    @(negedge clk) rst_n = 1'b1;
    #1;
    check("reset busy_vec", sbIf.busy_vec, 32'h0);
    check("reset busy_cnt", 32'(sbIf.busy_cnt), 32'd0);
    check("reset wb_err", 32'(sbIf.wb_err), 32'd0);

    for (int i = 0; i < vecs.size(); i++) begin
      v = vecs[i];
      @(negedge clk);
      apply(v);
      #1;
      check($sformatf("v%0d grant", i), 32'({sbIf.grant3, sbIf.grant2, sbIf.grant1}), 32'(v.expGrant));
      @(posedge clk);
      #1;
      check($sformatf("v%0d busy_vec", i), sbIf.busy_vec, v.expBusy);
      check($sformatf("v%0d busy_cnt", i), 32'(sbIf.busy_cnt), 32'(v.expCnt));
      check($sformatf("v%0d wb_err", i), 32'(sbIf.wb_err), 32'(v.expErr));
    end

    // asynchronous reset mid-cycle, no clock edge in between
    @(negedge clk);
    apply(idle);
    #2 rst_n = 1'b0;
    #1;
    check("async busy_vec", sbIf.busy_vec, 32'h0);
    check("async busy_cnt", 32'(sbIf.busy_cnt), 32'd0);
    check("async wb_err", 32'(sbIf.wb_err), 32'd0);
    @(negedge clk) rst_n = 1'b1;

    // writeback after reset targets a free register
    @(negedge clk);
    v = idle;
    v.wbEn = 3'b001;
    v.wbRd = {5'd0, 5'd0, 5'd5};
    apply(v);
    @(posedge clk);
    #1;
    check("post-reset wb_err", 32'(sbIf.wb_err), 32'd1);
    check("post-reset busy_vec", sbIf.busy_vec, 32'h0);

    @(negedge clk);
    apply(idle);
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
